// File: rtl/cu_sequencer.sv
// cu_sequencer: instruction-cycle FSM driving fetch/decode/execute/bus handshakes,
// holding PC and IR, with halt detection, per-phase watchdog and sticky fault code.
`default_nettype none

module cu_sequencer #(
    parameter int               IR_W     = 32,
    parameter int               ADDR_W   = 16,
    parameter int               OPC_W    = 4,
    parameter int               NUM_EU   = 2,
    parameter int               EU_IDW   = 2,
    parameter int               TIMEOUT  = 15,
    parameter logic [OPC_W-1:0] HALT_OPC = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IR_W-1:0]   ir_in,
    output logic              cs_fcu,
    input  logic              ready_fcu,
    output logic [ADDR_W-1:0] fetch_address,
    output logic              cs_dec,
    input  logic              ready_dec,
    input  logic              dec_mem,
    input  logic [EU_IDW-1:0] dec_eu,
    output logic [NUM_EU-1:0] cs_eu,
    input  logic [NUM_EU-1:0] ready_eu,
    output logic              cs_biu,
    input  logic              ready_bus,
    output logic [IR_W-1:0]   ir,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int                CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        HALT   = 3'd5,
        FAULT  = 3'd6
    } state_t;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   pc;
    logic [CNT_W-1:0]    wait_cnt;
    logic [EU_IDW-1:0]   eu_id;
    logic                mem_flag;
    logic [1:0]          next_fault_code;
    logic                ready_cur;
    logic                in_handshake;
    logic                is_halt_opc;
    logic                bad_eu;

    assign is_halt_opc = (ir[IR_W-1 -: OPC_W] == HALT_OPC);
    assign bad_eu      = (32'(dec_eu) >= NUM_EU);

    always_comb begin
        next_state      = state;
        next_fault_code = fault_code;
        ready_cur       = 1'b0;
        in_handshake    = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = FETCH;
            end
            FETCH: begin
                in_handshake = 1'b1;
                ready_cur    = ready_fcu;
                if (ready_fcu) next_state = DECODE;
            end
            DECODE: begin
                in_handshake = 1'b1;
                ready_cur    = ready_dec;
                if (ready_dec) begin
                    // Halt wins over an out-of-range EU index.
                    if (is_halt_opc) begin
                        next_state = HALT;
                    end else if (bad_eu) begin
                        next_state      = FAULT;
                        next_fault_code = 2'd2;
                    end else begin
                        next_state = EXEC;
                    end
                end
            end
            EXEC: begin
                in_handshake = 1'b1;
                for (int i = 0; i < NUM_EU; i++) begin
                    if (32'(eu_id) == i) ready_cur = ready_eu[i];
                end
                if (ready_cur) next_state = mem_flag ? MEM : FETCH;
            end
            MEM: begin
                in_handshake = 1'b1;
                ready_cur    = ready_bus;
                if (ready_bus) next_state = FETCH;
            end
            default: begin
                next_state = state;
            end
        endcase
        if (in_handshake && !ready_cur && (wait_cnt == WAIT_LAST)) begin
            next_state      = FAULT;
            next_fault_code = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= '0;
            ir         <= '0;
            wait_cnt   <= '0;
            eu_id      <= '0;
            mem_flag   <= 1'b0;
            fault_code <= 2'd0;
        end else begin
            state      <= next_state;
            fault_code <= next_fault_code;
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (in_handshake && !ready_cur) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == FETCH && ready_fcu) begin
                ir <= ir_in;
                pc <= pc + 1'b1;
            end
            if (state == DECODE && ready_dec) begin
                eu_id    <= dec_eu;
                mem_flag <= dec_mem;
            end
        end
    end

    always_comb begin
        cs_eu = '0;
        if (state == EXEC) begin
            for (int i = 0; i < NUM_EU; i++) begin
                if (32'(eu_id) == i) cs_eu[i] = 1'b1;
            end
        end
    end

    assign cs_fcu        = (state == FETCH);
    assign cs_dec        = (state == DECODE);
    assign cs_biu        = (state == MEM);
    assign busy          = (state == FETCH) || (state == DECODE) ||
                           (state == EXEC)  || (state == MEM);
    assign halted        = (state == HALT);
    assign fault         = (state == FAULT);
    assign fetch_address = pc;

endmodule

`default_nettype wire

// File: tb/tb_cu_sequencer.sv
// Directed self-checking bench for cu_sequencer with default parameters.
`default_nettype none

module tb_cu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] ir_in;
    logic        cs_fcu;
    logic        ready_fcu;
    logic [15:0] fetch_address;
    logic        cs_dec;
    logic        ready_dec;
    logic        dec_mem;
    logic [1:0]  dec_eu;
    logic [1:0]  cs_eu;
    logic [1:0]  ready_eu;
    logic        cs_biu;
    logic        ready_bus;
    logic [31:0] ir;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;

    int checks = 0;
    int errors = 0;

    cu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .ir_in(ir_in),
        .cs_fcu(cs_fcu), .ready_fcu(ready_fcu), .fetch_address(fetch_address),
        .cs_dec(cs_dec), .ready_dec(ready_dec), .dec_mem(dec_mem), .dec_eu(dec_eu),
        .cs_eu(cs_eu), .ready_eu(ready_eu), .cs_biu(cs_biu), .ready_bus(ready_bus),
        .ir(ir), .busy(busy), .halted(halted), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // cs vector order: {fcu, dec, eu[1:0], biu}
    function automatic logic [4:0] cs_all();
        return {cs_fcu, cs_dec, cs_eu, cs_biu};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; ir_in = '0;
        ready_fcu = 1'b0; ready_dec = 1'b0; ready_eu = 2'b00; ready_bus = 1'b0;
        dec_mem = 1'b0; dec_eu = 2'd0;
        step(); step();
        reset = 1'b1;
    endtask

    initial begin
        int n;
        // Reset state, with early readys while idle
        do_reset();
        check("rst_cs", 64'(cs_all()), 64'h0);
        check("rst_busy_halt_fault", 64'({busy, halted, fault, fault_code}), 64'h0);
        check("rst_pc_ir", 64'({fetch_address, ir}), 64'h0);
        ready_fcu = 1'b1; ready_dec = 1'b1; ready_eu = 2'b11; ready_bus = 1'b1;
        ir_in = 32'h1000_0000;
        step(); step();
        check("idle_ignores_ready", 64'({cs_all(), busy}), 64'h0);

        // Basic 3-cycle instruction with all readys high
        start = 1'b1;
        step(); start = 1'b0;
        check("t1_fetch", 64'({cs_all(), busy, fetch_address}), {42'h0, 5'b10000, 1'b1, 16'd0});
        step();
        check("t1_decode", 64'({cs_all(), fetch_address}), {43'h0, 5'b01000, 16'd1});
        check("t1_ir", 64'(ir), 64'h1000_0000);
        step();
        check("t1_exec", 64'({cs_all(), fetch_address}), {43'h0, 5'b00010, 16'd1});
        dec_mem = 1'b1; dec_eu = 2'd1; ready_bus = 1'b0;
        step();
        check("t1_fetch2", 64'({cs_all(), fetch_address}), {43'h0, 5'b10000, 16'd1});

        // Memory instruction on EU1, bus ready delayed 3 cycles
        step();
        check("t2_decode", 64'({cs_all(), fetch_address}), {43'h0, 5'b01000, 16'd2});
        step();
        check("t2_exec_eu1", 64'(cs_all()), 64'(5'b00100));
        step();
        n = 0;
        while (cs_biu && n < 10) begin
            n++;
            if (n == 4) ready_bus = 1'b1;
            step();
        end
        check("t2_biu_cycles", 64'(n), 64'd4);
        check("t2_back_to_fetch", 64'({cs_all(), fault}), {58'h0, 5'b10000, 1'b0});

        // Watchdog: fetch never completes
        do_reset();
        start = 1'b1;
        step();
        n = 0;
        while (cs_fcu && n < 40) begin
            n++;
            start = ~start;
            step();
        end
        check("t3_fcu_cycles", 64'(n), 64'd15);
        check("t3_fault", 64'({fault, fault_code, busy, halted}), 64'({1'b1, 2'd1, 1'b0, 1'b0}));
        for (int k = 0; k < 4; k++) begin
            start = ~start; ready_fcu = 1'b1;
            step();
        end
        check("t3_fault_terminal", 64'({cs_all(), fault, fault_code}), 64'({5'b0, 1'b1, 2'd1}));

        // Ready on the last allowed wait cycle wins over the timeout
        do_reset();
        start = 1'b1;
        step(); start = 1'b0;
        for (int k = 1; k < 15; k++) step();
        check("t4_still_fetch", 64'(cs_fcu), 64'd1);
        ready_fcu = 1'b1;
        step();
        check("t4_decode_no_fault", 64'({cs_all(), fault}), {58'h0, 5'b01000, 1'b0});

        // Halt opcode
        do_reset();
        ready_fcu = 1'b1; ready_dec = 1'b1; ready_eu = 2'b11; ready_bus = 1'b1;
        ir_in = 32'hF000_0000; dec_eu = 2'd3;
        start = 1'b1;
        step(); step(); step();
        check("t5_halted", 64'({halted, fault, busy, cs_all()}), 64'({1'b1, 1'b0, 1'b0, 5'b0}));
        check("t5_pc_ir", 64'({fetch_address, ir}), {16'h0, 16'd1, 32'hF000_0000});
        step(); step();
        check("t5_halt_sticky", 64'({halted, cs_all(), fetch_address}), {42'h0, 1'b1, 5'b0, 16'd1});

        // Bad EU index
        do_reset();
        ready_fcu = 1'b1; ready_dec = 1'b1; ready_eu = 2'b11; ready_bus = 1'b1;
        ir_in = 32'h2000_0000; dec_eu = 2'd3;
        start = 1'b1;
        step(); step(); step();
        check("t5_bad_eu", 64'({fault, fault_code, halted, busy, cs_all()}),
              64'({1'b1, 2'd2, 1'b0, 1'b0, 5'b0}));

        // Asynchronous reset while an EU request is pending
        do_reset();
        ready_fcu = 1'b1; ready_dec = 1'b1; ready_eu = 2'b00;
        ir_in = 32'h3000_0000; dec_eu = 2'd0; dec_mem = 1'b0;
        start = 1'b1;
        step(); start = 1'b0;
        step(); step();
        check("t6_exec", 64'(cs_all()), 64'(5'b00010));
        #2 reset = 1'b0;
        #1;
        check("t6_async_clear", 64'({cs_all(), busy, fetch_address, ir}), 64'h0);
        step();
        reset = 1'b1; ready_eu = 2'b11; start = 1'b1;
        step(); start = 1'b0;
        check("t6_restart", 64'({cs_all(), fetch_address}), {43'h0, 5'b10000, 16'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire
